// File: rtl/shoot_pkg.sv
// Shared types and constants for the enemy-fire scheduler.
// Optional build macro used by the block: SHOOT_SEED_LOAD_EN (runtime LFSR reseed).
`timescale 1ns/1ps
package shoot_pkg;

  // Scheduler states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_REQ  = 2'd2,
    ST_COOL = 2'd3
  } shoot_state_t;

  // Power-on seed; narrower LFSRs take the low bits.
  localparam logic [31:0] LFSR_SEED_DEFAULT = 32'hACE1_5EED;

  // Right-shifting Galois feedback masks (maximal length).
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
  localparam logic [23:0] LFSR_TAPS_24 = 24'hE10000;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h80200003;

  // Feedback mask for a supported width, zero-extended to 32 bits.
  function automatic logic [31:0] lfsr_taps(input int unsigned width);
    logic [31:0] taps;
    case (width)
      24:      taps = {8'h00, LFSR_TAPS_24};
      32:      taps = LFSR_TAPS_32;
      default: taps = {16'h0000, LFSR_TAPS_16};
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/shoot_lfsr.sv
// Free-running Galois LFSR that steps every pclk cycle.
// With SHOOT_SEED_LOAD_EN defined, a seed-load pulse replaces the next step with
// the supplied seed (zero maps to the default seed so the lock-up state is never entered).
`timescale 1ns/1ps
module shoot_lfsr
  import shoot_pkg::*;
#(
  parameter int LFSR_W = 16
) (
  input  logic              pclk,
  input  logic              rst,
`ifdef SHOOT_SEED_LOAD_EN
  input  logic              i_seed_load,
  input  logic [LFSR_W-1:0] i_seed,
`endif
  output logic [LFSR_W-1:0] o_lfsr
);

  localparam logic [31:0]       TAPS_ALL = lfsr_taps(LFSR_W);
  localparam logic [LFSR_W-1:0] TAPS     = TAPS_ALL[LFSR_W-1:0];
  localparam logic [LFSR_W-1:0] SEED     = LFSR_SEED_DEFAULT[LFSR_W-1:0];

  logic [LFSR_W-1:0] r_lfsr;
  logic [LFSR_W-1:0] w_step;
  logic [LFSR_W-1:0] w_next;

  // One Galois step: shift right, fold the taps in when a one falls out.
  always_comb begin
    w_step = r_lfsr >> 1;
    if (r_lfsr[0]) begin
      w_step = (r_lfsr >> 1) ^ TAPS;
    end
  end

`ifdef SHOOT_SEED_LOAD_EN
  // A seed load overrides the step; zero would lock the register, so it means default.
  always_comb begin
    w_next = w_step;
    if (i_seed_load) begin
      w_next = (i_seed == '0) ? SEED : i_seed;
    end
  end
`else
  // Without the reseed option the register only ever steps.
  always_comb begin
    w_next = w_step;
  end
`endif

  // State register, seeded by reset.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= w_next;
    end
  end

  assign o_lfsr = r_lfsr;

endmodule

// File: rtl/random_shoot_sched.sv
// Enemy-fire scheduler: once per frame the LFSR decides whether to fire, a rotating
// scan picks a live shooter from a random start slot, the choice is offered as a
// valid/ack request, then a frame-counted cooldown runs before the next decision.
// Optional build macro: SHOOT_SEED_LOAD_EN adds seed_load/seed for runtime reseeding.
//
// state | meaning
// IDLE  | waiting for a frame tick that wins the probability draw
// SCAN  | stepping the candidate slot until a live shooter is found
// REQ   | shot_valid high, waiting for shot_ack (withdrawn if shooter/enable lost)
// COOL  | counting down frames after an accepted shot
`timescale 1ns/1ps
module random_shoot_sched
  import shoot_pkg::*;
#(
  parameter  int N_ENEMIES = 8,
  parameter  int LFSR_W    = 16,
  parameter  int PROB_W    = 8,
  parameter  int COOL_W    = 6,
  localparam int IDX_W     = $clog2(N_ENEMIES)
) (
  input  logic                 pclk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 frame_tick,
  input  logic [N_ENEMIES-1:0] alive,
  input  logic [PROB_W-1:0]    threshold,
  input  logic [COOL_W-1:0]    cooldown,
  input  logic                 shot_ack,
`ifdef SHOOT_SEED_LOAD_EN
  input  logic                 seed_load,
  input  logic [LFSR_W-1:0]    seed,
`endif
  output logic                 shot_valid,
  output logic [IDX_W-1:0]     shot_idx,
  output logic                 busy
);

  localparam logic [IDX_W:0]   N_EXT = (IDX_W+1)'(N_ENEMIES);
  localparam logic [IDX_W-1:0] N_M1  = IDX_W'(N_ENEMIES - 1);

  shoot_state_t r_state;
  logic [IDX_W-1:0]  r_cand;
  logic [IDX_W-1:0]  r_miss;
  logic [COOL_W-1:0] r_cnt;
  logic              r_valid;
  logic [IDX_W-1:0]  r_idx;
  logic              r_busy;

  logic [LFSR_W-1:0] w_lfsr;
  logic [IDX_W-1:0]  w_start_raw;
  logic [IDX_W-1:0]  w_start;
  logic [IDX_W-1:0]  w_cand_next;
  logic              w_fire;
  logic              w_unused_lfsr;

  shoot_lfsr #(
    .LFSR_W(LFSR_W)
  ) u_lfsr (
    .pclk       (pclk),
    .rst        (rst),
`ifdef SHOOT_SEED_LOAD_EN
    .i_seed_load(seed_load),
    .i_seed     (seed),
`endif
    .o_lfsr     (w_lfsr)
  );

  // Only the top and bottom fields of the LFSR feed decisions.
  assign w_unused_lfsr = ^w_lfsr;

  // Start slot from the LFSR top bits, folded once into range for non-power-of-two counts.
  always_comb begin
    w_start_raw = w_lfsr[LFSR_W-1 -: IDX_W];
    w_start     = w_start_raw;
    if ({1'b0, w_start_raw} >= N_EXT) begin
      w_start = IDX_W'({1'b0, w_start_raw} - N_EXT);
    end
  end

  // Next candidate in the rotation, and the per-frame fire decision.
  always_comb begin
    w_cand_next = (r_cand == N_M1) ? '0 : r_cand + 1'b1;
    w_fire      = frame_tick & enable & (|alive) & (w_lfsr[PROB_W-1:0] < threshold);
  end

  // Scheduler FSM with registered request outputs.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cand  <= '0;
      r_miss  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_fire) begin
            r_state <= ST_SCAN;
            r_cand  <= w_start;
            r_miss  <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (!enable) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (alive[r_cand]) begin
            r_state <= ST_REQ;
            r_idx   <= r_cand;
            r_valid <= 1'b1;
          end else if (r_miss == N_M1) begin
            // a full lap without a live slot: the mask emptied after the draw
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cand  <= w_cand_next;
            r_miss  <= r_miss + 1'b1;
          end
        end
        ST_REQ: begin
          // losing the shooter or the enable beats a simultaneous ack
          if (!enable || !alive[r_idx]) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end else if (shot_ack) begin
            r_state <= ST_COOL;
            r_cnt   <= cooldown;
            r_valid <= 1'b0;
          end
        end
        ST_COOL: begin
          if (r_cnt == '0) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (frame_tick) begin
            r_cnt   <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign shot_valid = r_valid;
  assign shot_idx   = r_idx;
  assign busy       = r_busy;

endmodule

// File: tb/tb_random_shoot_sched.sv
// Self-checking bench for random_shoot_sched (default parameters).
// Seed-load scenarios are compiled in when SHOOT_SEED_LOAD_EN is defined.
`timescale 1ns/1ps
module tb_random_shoot_sched;

  localparam int N  = 8;
  localparam int LW = 16;
  localparam int PW = 8;
  localparam int CW = 6;
  localparam int IW = 3;

  logic          pclk       = 1'b0;
  logic          rst        = 1'b0;
  logic          enable     = 1'b0;
  logic          frame_tick = 1'b0;
  logic [N-1:0]  alive      = '0;
  logic [PW-1:0] threshold  = '0;
  logic [CW-1:0] cooldown   = '0;
  logic          shot_ack;
  logic          shot_valid;
  logic [IW-1:0] shot_idx;
  logic          busy;

  logic ack_auto   = 1'b0;
  logic ack_manual = 1'b0;
  logic auto_ack   = 1'b0;
  assign shot_ack = ack_auto ? auto_ack : ack_manual;

`ifdef SHOOT_SEED_LOAD_EN
  logic          seed_load = 1'b0;
  logic [LW-1:0] seed      = '0;
  logic [IW-1:0] cap_a[$];
`endif

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;
  logic capture = 1'b0;
  logic prev_valid = 1'b0;
  int dut_pulses = 0;
  int vcnt = 0;
  logic [IW-1:0] cap_q[$];

  // Model state
  logic [LW-1:0] m_lfsr   = 16'h5EED;
  int            m_phase  = 0;   // 0 idle, 1 choosing, 2 requesting, 3 cooling
  int            m_wait   = 0;
  int            m_target = 0;
  int            m_idx    = 0;
  int            m_frames = 0;
  int            m_shots  = 0;

  always #5 pclk = ~pclk;

  random_shoot_sched dut (
    .pclk      (pclk),
    .rst       (rst),
    .enable    (enable),
    .frame_tick(frame_tick),
    .alive     (alive),
    .threshold (threshold),
    .cooldown  (cooldown),
    .shot_ack  (shot_ack),
`ifdef SHOOT_SEED_LOAD_EN
    .seed_load (seed_load),
    .seed      (seed),
`endif
    .shot_valid(shot_valid),
    .shot_idx  (shot_idx),
    .busy      (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [LW-1:0] lstep(input logic [LW-1:0] x);
    logic [LW-1:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ 16'hB400;
    return y;
  endfunction

  // Behavioural model: the chosen shooter is computed in one go as the first live
  // slot at or after the random start, and its arrival is a countdown of edges.
  initial begin : model
    forever begin
      @(posedge pclk or negedge rst);
      if (!rst) begin
        m_lfsr = 16'h5EED; m_phase = 0; m_wait = 0; m_target = 0; m_idx = 0; m_frames = 0;
      end else begin
        case (m_phase)
          0: if (frame_tick && enable && (|alive) && (m_lfsr[PW-1:0] < threshold)) begin
               int s;
               bit found;
               s = int'(m_lfsr[LW-1 -: IW]);
               if (s >= N) s = s - N;
               found = 1'b0;
               for (int k = 0; k < N; k++) begin
                 if (!found && alive[(s + k) % N]) begin
                   found = 1'b1; m_target = (s + k) % N; m_wait = k;
                 end
               end
               m_phase = 1;
             end
          1: if (!enable) m_phase = 0;
             else if (m_wait == 0) begin m_phase = 2; m_idx = m_target; end
             else m_wait = m_wait - 1;
          2: if (!enable || !alive[m_idx]) m_phase = 0;
             else if (shot_ack) begin m_phase = 3; m_frames = int'(cooldown); m_shots++; end
          default: if (m_frames == 0) m_phase = 0;
                   else if (frame_tick) m_frames = m_frames - 1;
        endcase
`ifdef SHOOT_SEED_LOAD_EN
        if (seed_load) m_lfsr = (seed == '0) ? 16'h5EED : seed;
        else m_lfsr = lstep(m_lfsr);
`else
        m_lfsr = lstep(m_lfsr);
`endif
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin : compare
    forever begin
      @(negedge pclk);
      if (rst && cmp_en) begin
        chk("cyc_valid", 32'(shot_valid), 32'(m_phase == 2));
        chk("cyc_busy",  32'(busy),       32'(m_phase != 0));
        chk("cyc_idx",   32'(shot_idx),   32'(m_idx));
        chk("cyc_lfsr",  32'(dut.w_lfsr), 32'(m_lfsr));
      end
    end
  end

  // Ack responder: acknowledges one cycle after valid is first seen.
  initial begin : responder
    forever begin
      @(negedge pclk);
      if (ack_auto && shot_valid) begin
        vcnt++;
        auto_ack = (vcnt >= 2);
      end else begin
        vcnt = 0;
        auto_ack = 1'b0;
      end
    end
  end

  // Request pulse monitor.
  initial begin : pmon
    forever begin
      @(negedge pclk);
      if (rst && shot_valid && !prev_valid) begin
        dut_pulses++;
        if (capture) cap_q.push_back(shot_idx);
      end
      prev_valid = shot_valid;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int period);
    @(negedge pclk); frame_tick = 1'b1;
    @(negedge pclk); frame_tick = 1'b0;
    repeat (period - 2) @(negedge pclk);
  endtask

  // Tick once and wait (bounded) for a request; n counts edges from the tick edge.
  task automatic fire(output bit got, output int n);
    bit mf;
    @(negedge pclk); frame_tick = 1'b1;
    @(negedge pclk); frame_tick = 1'b0;
    mf  = (m_phase == 1) || (m_phase == 2);
    n   = 1;
    got = shot_valid;
    while (!got && n < 12) begin
      @(negedge pclk);
      n++;
      got = shot_valid;
    end
    if (mf) chk("valid_timeout", 32'(got), 32'd1);
  endtask

`ifdef SHOOT_SEED_LOAD_EN
  task automatic load_seed(input logic [LW-1:0] v);
    @(negedge pclk); seed = v; seed_load = 1'b1;
    @(negedge pclk); seed_load = 1'b0;
  endtask
`endif

  initial begin : main
    bit got;
    int n;
    int p0;
    int s0;

    // Reset
    #199;
    chk("rst_valid", 32'(shot_valid), 32'd0);
    chk("rst_busy",  32'(busy),       32'd0);
    chk("rst_idx",   32'(shot_idx),   32'd0);
    #1; rst = 1'b1;
    #1;
    chk("rst_lfsr_dut",   32'(dut.w_lfsr), 32'h5EED);
    chk("rst_lfsr_model", 32'(m_lfsr),     32'h5EED);
    @(posedge pclk); #1;
    chk("lfsr_step_dut",   32'(dut.w_lfsr), 32'h9B76);
    chk("lfsr_step_model", 32'(m_lfsr),     32'h9B76);
    cmp_en = 1'b1;

    // Always fire: one accepted shot per three frames at most
    @(negedge pclk);
    enable = 1'b1; alive = 8'hFF; threshold = 8'hFF; cooldown = 6'd2; ack_auto = 1'b1;
    s0 = m_shots; p0 = dut_pulses;
    repeat (30) tick(16);
    repeat (16) @(negedge pclk);
    chk("always_shots_range", 32'(((m_shots - s0) >= 8) && ((m_shots - s0) <= 10)), 32'd1);
    chk("always_pulses", 32'(dut_pulses - p0), 32'(m_shots - s0));

    // Never fire
    threshold = 8'h00; cooldown = 6'd0;
    p0 = dut_pulses;
    repeat (1000) tick(4);
    chk("never_pulses", 32'(dut_pulses - p0), 32'd0);

    // Single survivor
    alive = 8'b0010_0000; threshold = 8'hFF;
    repeat (8) @(negedge pclk);
    repeat (6) begin
      fire(got, n);
      if (got) begin
        chk("survivor_idx", 32'(shot_idx), 32'd5);
        chk("survivor_latency_le9", 32'(n <= 9), 32'd1);
      end
      repeat (8) @(negedge pclk);
    end

    // Withdrawal on shooter loss
    alive = 8'hFF; cooldown = 6'd3; ack_auto = 1'b0; ack_manual = 1'b0;
    repeat (4) @(negedge pclk);
    fire(got, n);
    if (got) begin
      alive[shot_idx] = 1'b0;
      @(negedge pclk);
      chk("wd_valid", 32'(shot_valid), 32'd0);
      chk("wd_busy",  32'(busy),       32'd0);
    end
    alive = 8'hFF;
    repeat (4) @(negedge pclk);

    // Ack and kill together: withdrawal wins, no cooldown
    fire(got, n);
    if (got) begin
      ack_manual = 1'b1; alive[shot_idx] = 1'b0;
      @(negedge pclk);
      ack_manual = 1'b0;
      chk("ackkill_valid", 32'(shot_valid), 32'd0);
      chk("ackkill_busy",  32'(busy),       32'd0);
    end
    alive = 8'hFF;
    repeat (4) @(negedge pclk);

    // Enable drop withdraws a pending request
    fire(got, n);
    if (got) begin
      enable = 1'b0;
      @(negedge pclk);
      chk("en_drop_valid", 32'(shot_valid), 32'd0);
      chk("en_drop_busy",  32'(busy),       32'd0);
    end
    enable = 1'b1;
    repeat (4) @(negedge pclk);

    // Enable low does not abort cooldown
    fire(got, n);
    if (got) begin
      ack_manual = 1'b1;
      @(negedge pclk);
      ack_manual = 1'b0; enable = 1'b0;
      @(negedge pclk);
      chk("cool_holds_busy", 32'(busy), 32'd1);
      repeat (3) tick(8);
      chk("cool_done_busy", 32'(busy), 32'd0);
    end
    enable = 1'b1;
    repeat (4) @(negedge pclk);

    // Asynchronous reset in the middle of a request
    fire(got, n);
    #2; rst = 1'b0;
    #1;
    chk("async_valid", 32'(shot_valid), 32'd0);
    chk("async_busy",  32'(busy),       32'd0);
    @(negedge pclk); rst = 1'b1;
    #1;
    chk("async_lfsr", 32'(dut.w_lfsr), 32'h5EED);

`ifdef SHOOT_SEED_LOAD_EN
    // Reseeding replays the same shooter sequence
    alive = 8'hFF; threshold = 8'h80; cooldown = 6'd0; ack_auto = 1'b1;
    repeat (4) @(negedge pclk);
    load_seed(16'h0001);
    chk("seed_load_val", 32'(dut.w_lfsr), 32'h0001);
    cap_q.delete(); capture = 1'b1;
    repeat (12) tick(16);
    repeat (16) @(negedge pclk);
    capture = 1'b0;
    cap_a = cap_q;
    load_seed(16'h0001);
    cap_q.delete(); capture = 1'b1;
    repeat (12) tick(16);
    repeat (16) @(negedge pclk);
    capture = 1'b0;
    chk("seed_replay_len", 32'(cap_q.size()), 32'(cap_a.size()));
    for (int i = 0; i < cap_a.size() && i < cap_q.size(); i++) begin
      chk("seed_replay_idx", 32'(cap_q[i]), 32'(cap_a[i]));
    end
    load_seed(16'h0000);
    chk("seed_zero_default", 32'(dut.w_lfsr), 32'h5EED);
`endif

    repeat (4) @(negedge pclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
